// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants, classification and FSM state types for the FPU
// add/subtract datapath.
//   EXP_MAX, QNAN      : IEEE-754 single-precision constants
//   fp_class_t         : operand class after denormal flush
//   fsm_state_t        : sequencing states of the iterative subtractor
//   shr_sticky()       : one-bit right shift of a working mantissa that
//                        keeps the lost bit alive in the sticky position
package fpu_pkg;

  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  // {carry, hidden, 23 frac, G, R, S}
  localparam int          MANT_W  = 28;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADDSUB, NORM, PACK, DONE} fsm_state_t;

  function automatic logic [MANT_W-1:0] shr_sticky(input logic [MANT_W-1:0] m);
    return {1'b0, m[MANT_W-1:2], m[1] | m[0]};
  endfunction

endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational IEEE-754 single-precision operand classifier.
// Denormals (exp == 0) are reported as ZERO, matching the flush-to-zero
// behaviour of the FPU datapath.
//   op   in  [31:0]  operand
//   sign out         operand sign bit
//   cls  out         ZERO / NORMAL / INF / NAN
module fp_classify
  import fpu_pkg::*;
(
  input  logic [31:0] op,
  output logic        sign,
  output fp_class_t   cls
);

  logic [7:0]  exp_f;
  logic [22:0] frac_f;

  assign sign   = op[31];
  assign exp_f  = op[30:23];
  assign frac_f = op[22:0];

  always_comb begin
    if (exp_f == 8'h00)        cls = ZERO;
    else if (exp_f == EXP_MAX) cls = (frac_f == 23'h0) ? INF : NAN;
    else                       cls = NORMAL;
  end

endmodule

// File: rtl/fp_subtractor_seq.sv
// fp_subtractor_seq: multi-cycle IEEE-754 single-precision subtractor,
// result = a - b, with one-bit-per-cycle align and normalize shifters.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a, b                 minuend / subtrahend
//   out_valid/out_ready  result handshake; result held until accepted
//   result               a - b
//   busy                 high whenever the FSM is not IDLE
// Build option: define FPSUB_RNE_EN for round-to-nearest-even; otherwise
// the guard/round/sticky bits are truncated.
//
// state  | meaning
// IDLE   | waiting for operands
// UNPACK | classify, resolve special cases, order operands by magnitude
// ALIGN  | shift smaller mantissa right one bit per cycle
// ADDSUB | effective add or subtract of the aligned mantissas
// NORM   | carry renormalize, or left shift one bit per cycle
// PACK   | round, overflow check, assemble result
// DONE   | result presented until out_ready
module fp_subtractor_seq
  import fpu_pkg::*;
#(
  parameter int ALIGN_CAP = 27,
  parameter int NORM_CAP  = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  localparam int CNT_W = $clog2(((ALIGN_CAP > NORM_CAP) ? ALIGN_CAP : NORM_CAP) + 1);

  fsm_state_t        state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [MANT_W-1:0] ml_q, ml_d, ms_q, ms_d;
  logic [9:0]        exp_q, exp_d;
  logic [7:0]        diff_q, diff_d;
  logic [CNT_W-1:0]  align_cnt_q, align_cnt_d, norm_cnt_q, norm_cnt_d;
  logic              sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       result_q, result_d;

  fp_class_t         cls_a, cls_b;
  logic              sa, sb, sb_eff, a_ge_b, special;
  logic [31:0]       special_res;
  logic [7:0]        exp_a, exp_b, diff_ab;
  logic [MANT_W-1:0] man_a, man_b, ms_shift, sum;
  logic              round_inc;
  logic [24:0]       mant_rnd;
  logic [9:0]        exp_rnd;
  logic [22:0]       frac_rnd;

  fp_classify u_cls_a (.op(a_q), .sign(sa), .cls(cls_a));
  fp_classify u_cls_b (.op(b_q), .sign(sb), .cls(cls_b));

  assign sb_eff   = ~sb;
  assign exp_a    = a_q[30:23];
  assign exp_b    = b_q[30:23];
  assign man_a    = {2'b01, a_q[22:0], 3'b000};
  assign man_b    = {2'b01, b_q[22:0], 3'b000};
  assign a_ge_b   = (a_q[30:0] >= b_q[30:0]);
  assign diff_ab  = a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a);
  assign ms_shift = shr_sticky(ms_q);
  // L >= S by construction, so the subtraction never wraps.
  assign sum      = eff_sub_q ? (ml_q - ms_q) : (ml_q + ms_q);

  always_comb begin
    special     = 1'b1;
    special_res = QNAN;
    if (cls_a == NAN || cls_b == NAN)                    special_res = QNAN;
    else if (cls_a == INF && cls_b == INF && sa == sb)   special_res = QNAN;
    else if (cls_a == INF)                               special_res = a_q;
    else if (cls_b == INF)                               special_res = {~sb, EXP_MAX, 23'h0};
    else if (cls_a == ZERO && cls_b == ZERO)             special_res = {sa & ~sb, 31'h0};
    else if (cls_a == ZERO)                              special_res = {~sb, b_q[30:0]};
    else if (cls_b == ZERO)                              special_res = a_q;
    else                                                 special = 1'b0;
  end

  always_comb begin
`ifdef FPSUB_RNE_EN
    round_inc = ml_q[2] & (ml_q[1] | ml_q[0] | ml_q[3]);
`else
    round_inc = 1'b0;
`endif
    mant_rnd = {1'b0, ml_q[26:3]} + {24'h0, round_inc};
    if (mant_rnd[24]) begin
      exp_rnd  = exp_q + 10'd1;
      frac_rnd = mant_rnd[23:1];
    end else begin
      exp_rnd  = exp_q;
      frac_rnd = mant_rnd[22:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ml_d        = ml_q;
    ms_d        = ms_q;
    exp_d       = exp_q;
    diff_d      = diff_q;
    align_cnt_d = align_cnt_q;
    norm_cnt_d  = norm_cnt_q;
    sign_d      = sign_q;
    eff_sub_d   = eff_sub_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        if (special) begin
          result_d    = special_res;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          ml_d        = a_ge_b ? man_a : man_b;
          ms_d        = a_ge_b ? man_b : man_a;
          exp_d       = {2'b00, (a_ge_b ? exp_a : exp_b)};
          sign_d      = a_ge_b ? sa : sb_eff;
          eff_sub_d   = (sa != sb_eff);
          diff_d      = diff_ab;
          align_cnt_d = CNT_W'(ALIGN_CAP);
          state_d     = (diff_ab == 8'd0) ? ADDSUB : ALIGN;
        end
      end
      ALIGN: begin
        diff_d      = diff_q - 8'd1;
        align_cnt_d = align_cnt_q - CNT_W'(1);
        if (diff_q == 8'd1) begin
          ms_d    = ms_shift;
          state_d = ADDSUB;
        end else if (align_cnt_q == CNT_W'(1)) begin
          // Out of shift budget: only the sticky information survives.
          ms_d    = {{(MANT_W-1){1'b0}}, |ms_shift};
          state_d = ADDSUB;
        end else begin
          ms_d = ms_shift;
        end
      end
      ADDSUB: begin
        ml_d       = sum;
        norm_cnt_d = CNT_W'(NORM_CAP);
        // Already normalized results skip NORM entirely.
        state_d    = (sum[27] || !sum[26]) ? NORM : PACK;
      end
      NORM: begin
        if (ml_q[27]) begin
          ml_d    = shr_sticky(ml_q);
          exp_d   = exp_q + 10'd1;
          state_d = PACK;
        end else if (ml_q == '0) begin
          result_d    = 32'h0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (exp_q == 10'd1 || norm_cnt_q == '0) begin
          result_d    = {sign_q, 31'h0};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          ml_d       = {ml_q[26:0], 1'b0};
          exp_d      = exp_q - 10'd1;
          norm_cnt_d = norm_cnt_q - CNT_W'(1);
          if (ml_q[25]) state_d = PACK;
        end
      end
      PACK: begin
        if (exp_rnd >= {2'b00, EXP_MAX}) result_d = {sign_q, EXP_MAX, 23'h0};
        else                             result_d = {sign_q, exp_rnd[7:0], frac_rnd};
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ml_q        <= '0;
      ms_q        <= '0;
      exp_q       <= '0;
      diff_q      <= '0;
      align_cnt_q <= '0;
      norm_cnt_q  <= '0;
      sign_q      <= 1'b0;
      eff_sub_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ml_q        <= ml_d;
      ms_q        <= ms_d;
      exp_q       <= exp_d;
      diff_q      <= diff_d;
      align_cnt_q <= align_cnt_d;
      norm_cnt_q  <= norm_cnt_d;
      sign_q      <= sign_d;
      eff_sub_q   <= eff_sub_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
